move_ctrl_2048: RTL
===================

Name: move_ctrl_2048

Overview:
- Game-logic controller for the 2048 top level: owns the 4x4 board register and sequences each move.
- Per move: slide and merge one line per cycle through a row-merge unit, spawn a new tile from an LFSR, then evaluate win and loss.
- Sits between the direction-command source (button debounce) and the display consumers (VGA renderer for board, seven-seg for score).

Parameters:
WIN_EXP, 11, tile exponent that sets won (2^11 = 2048)
SEED, 16'hACE1, LFSR value loaded at reset

Ports:
clk  in  1  system clock
clr_n  in  1  synchronous active-low reset
dir_valid  in  1  move request
dir  in  2  0=up 1=down 2=left 3=right
dir_ready  out  1  move accepted when dir_valid&&dir_ready
ld_en  in  1  board load strobe (honoured only in IDLE, lower priority than dir)
ld_board  in  64  board image for load
board  out  64  cell i=row*4+col at [4i+3:4i]; 4-bit exponent, 0=empty
score  out  16  running score, saturating
busy  out  1  high in any state other than IDLE
move_done  out  1  one-cycle pulse at the end of each move (in EVAL)
changed  out  1  valid with move_done; board differed after merge
won  out  1  sticky
lost  out  1  sticky

Behaviour:
- Reset: clk edge with clr_n=0, from any state including mid-move.
  - Outputs/state: board=0, score=0, won=lost=move_done=changed=0, LFSR=SEED, state=INIT.
  - dir_ready=0 and busy=1 during INIT.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every clock that is not a reset.
- States:
  - INIT: spawns 2 tiles via SPAWN (spawn counter=2), then goes to IDLE. No EVAL after INIT.
  - IDLE: dir_ready = !won && !lost.
    - On accept: latch dir, row=0, changed_acc=0, go to MERGE.
    - Else if ld_en: board<=ld_board and stay in IDLE. score and flags are unchanged.
  - MERGE: 4 cycles, row=0..3. Line j is extracted by direction:
    - left: cols 0..3 of row j
    - right: cols 3..0 of row j
    - up: rows 0..3 of col j
    - down: rows 3..0 of col j
    - The merged line is written back to the same cells in the same cycle.
    - changed_acc |= line changed; score += merge points (saturate at 16'hFFFF).
    - After row 3: go to SPAWN if changed_acc, else go to EVAL.
  - SPAWN: scan pointer starts at LFSR[3:0] and advances +1 mod 16 per cycle until an empty cell is found (max 16 cycles).
    - Write exponent 2 if LFSR[15:12]==0, else exponent 1.
    - Then go to EVAL (move) or to the next spawn/IDLE (INIT).
  - EVAL: 1 cycle.
    - Pulse move_done; changed=changed_acc.
    - won|= any cell >= WIN_EXP.
    - lost|= no empty cell && no horizontally or vertically adjacent equal nonzero pair.
    - Return to IDLE.
- Merge rules (row_merge):
  - Compact nonzeros toward index 0.
  - Merge each equal adjacent pair once, scanning from index 0; a merged tile does not merge again in the same move.
  - Merged exponent is e+1, capped at 15; each merge adds 2^(e+1) points.
- Latency, accept to move_done:
  - changed=0: 5 cycles (4 MERGE + EVAL).
  - changed=1: 5+k cycles, k=1..16 spawn scan cycles.
- dir_valid during busy is ignored and must be held by the requester. ld_en outside IDLE is ignored.
- Full board can occur only if changed=0, so SPAWN always finds an empty cell.

Decomposition:
- Package game2048_pkg holds:
  - EXP_W=4, CELLS=16
  - direction encodings DIR_UP/DOWN/LEFT/RIGHT
  - state enum INIT/IDLE/MERGE/SPAWN/EVAL
  - LFSR tap constant
- Sub-module row_merge: combinational.
  - Inputs: four 4-bit exponents.
  - Outputs: four merged exponents, 16-bit points, line_changed.
- Line extract/insert and lost/won detection stay in move_ctrl_2048.

Test Plan:
1. Reset, then release clr_n:
   - busy=1, two nonzero cells with exponent 1 or 2.
   - Positions match the SEED-derived golden model; then dir_ready=1.
2. ld_board row0=[1,1,1,1], other cells 0; move left:
   - row0=[2,2,0,0], score+=8, changed=1.
   - One new tile in an empty cell; move_done within 6..21 cycles.
3. ld row0=[1,1,2,0], other cells 0; move left:
   - row0=[2,2,0,0] with no chain merge, score+=4.
4. ld board with rows [1,2,3,4] repeated so columns are equal; move left:
   - changed=0, board unchanged, no spawn, score unchanged, move_done exactly 5 cycles after accept.
5. ld full checkerboard of 1/2 exponents; any move:
   - changed=0, lost=1, dir_ready stays 0.
   - Pulse clr_n low mid-MERGE on a later run: full reset state returns.
6. ld row0=[10,10,0,0]; move right:
   - row0=[0,0,0,11], score+=2048, won=1, dir_ready=0.

Source files
------------

// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 game-logic controller.
package game2048_pkg;

    localparam int unsigned EXP_W = 4;
    localparam int unsigned CELLS = 16;

    localparam logic [EXP_W-1:0] MAX_EXP = '1;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Fibonacci taps 16,14,13,11 on a left-shifting register (bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        MERGE,
        SPAWN,
        EVAL
    } state_t;

    function automatic logic [EXP_W-1:0] cell_at(input logic [CELLS*EXP_W-1:0] b,
                                                 input logic [3:0] i);
        return b[{i, 2'b00} +: EXP_W];
    endfunction

endpackage

// File: rtl/move_ctrl_2048_row_merge.sv
// Combinational slide-and-merge of one 4-cell line toward index 0.
module row_merge
    import game2048_pkg::*;
(
    input  logic [3:0][EXP_W-1:0] line_in,
    output logic [3:0][EXP_W-1:0] line_out,
    output logic [15:0]           points,
    output logic                  line_changed
);

    logic [EXP_W-1:0] packed_q [5];
    logic [2:0]       n;
    logic [1:0]       k;
    logic             skip;
    logic [17:0]      sum;

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) packed_q[i] = '0;
        n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (line_in[i] != '0) begin
                packed_q[n] = line_in[i];
                n = n + 3'd1;
            end
        end

        // Slot 4 stays empty so the pair test at index 3 never matches.
        line_out = '0;
        k        = '0;
        skip     = 1'b0;
        sum      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (packed_q[i] != '0) begin
                if (packed_q[i+1] == packed_q[i]) begin
                    line_out[k] = (packed_q[i] == MAX_EXP) ? MAX_EXP : packed_q[i] + EXP_W'(1);
                    sum  = sum + (18'd1 << ({1'b0, packed_q[i]} + 5'd1));
                    skip = 1'b1;
                end else begin
                    line_out[k] = packed_q[i];
                end
                k = k + 2'd1;
            end
        end
    end

    assign points       = (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
    assign line_changed = (line_out != line_in);

endmodule

// File: rtl/move_ctrl_2048.sv
// 2048 game controller: owns the board, merges one line per cycle, spawns tiles, tracks win/loss.
module move_ctrl_2048
    import game2048_pkg::*;
#(
    parameter int unsigned WIN_EXP = 11,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        dir_valid,
    input  logic [1:0]  dir,
    output logic        dir_ready,
    input  logic        ld_en,
    input  logic [63:0] ld_board,
    output logic [63:0] board,
    output logic [15:0] score,
    output logic        busy,
    output logic        move_done,
    output logic        changed,
    output logic        won,
    output logic        lost
);

    state_t      state;
    logic [15:0] lfsr;
    logic [1:0]  dir_q;
    logic [1:0]  row;
    logic        changed_acc;
    logic [1:0]  spawn_cnt;
    logic        in_init;
    logic        first;
    logic [3:0]  ptr;
    logic [EXP_W-1:0] val_q;

    logic [3:0]             idx [4];
    logic [3:0][EXP_W-1:0]  line_in;
    logic [3:0][EXP_W-1:0]  line_out;
    logic [15:0]            points;
    logic                   line_changed;
    logic [63:0]            merged_board;
    logic [16:0]            score_sum;
    logic [15:0]            score_next;

    logic [3:0]       cur;
    logic             cell_empty;
    logic [EXP_W-1:0] spawn_val;
    logic             any_win;
    logic             any_empty;
    logic             any_pair;

    assign busy      = (state != IDLE);
    assign dir_ready = (state == IDLE) && !won && !lost;

    // Line j is read in slide order so row_merge always compacts toward index 0.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            case (dir_q)
                DIR_LEFT:  idx[i] = {row, 2'(i)};
                DIR_RIGHT: idx[i] = {row, 2'(3 - i)};
                DIR_UP:    idx[i] = {2'(i), row};
                default:   idx[i] = {2'(3 - i), row};
            endcase
            line_in[i] = cell_at(board, idx[i]);
        end
    end

    always_comb begin
        merged_board = board;
        for (int unsigned i = 0; i < 4; i++) begin
            merged_board[{idx[i], 2'b00} +: EXP_W] = line_out[i];
        end
    end

    row_merge u_row_merge (
        .line_in      (line_in),
        .line_out     (line_out),
        .points       (points),
        .line_changed (line_changed)
    );

    assign score_sum  = {1'b0, score} + {1'b0, points};
    assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // The first scan cycle of each spawn takes position and value straight from the LFSR.
    assign cur        = first ? lfsr[3:0] : ptr;
    assign cell_empty = (cell_at(board, cur) == '0);
    assign spawn_val  = first ? ((lfsr[15:12] == 4'd0) ? EXP_W'(2) : EXP_W'(1)) : val_q;

    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (cell_at(board, {2'(r), 2'(c)}) >= EXP_W'(WIN_EXP)) any_win = 1'b1;
                if (cell_at(board, {2'(r), 2'(c)}) == '0) any_empty = 1'b1;
                if (c < 3 && cell_at(board, {2'(r), 2'(c)}) != '0 &&
                    cell_at(board, {2'(r), 2'(c)}) == cell_at(board, {2'(r), 2'(c + 1)}))
                    any_pair = 1'b1;
                if (r < 3 && cell_at(board, {2'(r), 2'(c)}) != '0 &&
                    cell_at(board, {2'(r), 2'(c)}) == cell_at(board, {2'(r + 1), 2'(c)}))
                    any_pair = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state       <= INIT;
            lfsr        <= SEED;
            board       <= '0;
            score       <= '0;
            won         <= 1'b0;
            lost        <= 1'b0;
            move_done   <= 1'b0;
            changed     <= 1'b0;
            dir_q       <= '0;
            row         <= '0;
            changed_acc <= 1'b0;
            spawn_cnt   <= '0;
            in_init     <= 1'b0;
            first       <= 1'b0;
            ptr         <= '0;
            val_q       <= '0;
        end else begin
            lfsr      <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            move_done <= 1'b0;
            case (state)
                INIT: begin
                    spawn_cnt <= 2'd2;
                    in_init   <= 1'b1;
                    first     <= 1'b1;
                    state     <= SPAWN;
                end
                IDLE: begin
                    if (dir_valid && !won && !lost) begin
                        dir_q       <= dir;
                        row         <= '0;
                        changed_acc <= 1'b0;
                        state       <= MERGE;
                    end else if (ld_en) begin
                        board <= ld_board;
                    end
                end
                MERGE: begin
                    board       <= merged_board;
                    changed_acc <= changed_acc | line_changed;
                    score       <= score_next;
                    row         <= row + 2'd1;
                    if (row == 2'd3) begin
                        if (changed_acc | line_changed) begin
                            spawn_cnt <= 2'd1;
                            in_init   <= 1'b0;
                            first     <= 1'b1;
                            state     <= SPAWN;
                        end else begin
                            state <= EVAL;
                        end
                    end
                end
                SPAWN: begin
                    first <= 1'b0;
                    val_q <= spawn_val;
                    if (cell_empty) begin
                        board[{cur, 2'b00} +: EXP_W] <= spawn_val;
                        if (spawn_cnt == 2'd1) begin
                            state <= in_init ? IDLE : EVAL;
                        end else begin
                            spawn_cnt <= spawn_cnt - 2'd1;
                            first     <= 1'b1;
                        end
                    end else begin
                        ptr <= cur + 4'd1;
                    end
                end
                EVAL: begin
                    move_done <= 1'b1;
                    changed   <= changed_acc;
                    won       <= won | any_win;
                    lost      <= lost | (!any_empty && !any_pair);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
